// File: rtl/flex_down_counter_if.sv
// Control/status bundle for the loadable down-counter.
// Latency: pure wiring, none.
// Backpressure: none; the counter samples its controls every cycle.
interface flex_down_counter_if #(
  parameter int NUM_CNT_BITS = 4
) ();
  logic                    clear;
  logic                    load;
  logic [NUM_CNT_BITS-1:0] load_val;
  logic                    count_enable;
  logic                    auto_reload;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    expire_pulse;
  logic                    busy;
  logic                    zero_flag;

  // Controller side: drives the controls, observes count and status.
  modport master (
    output clear, load, load_val, count_enable, auto_reload,
    input  count_out, expire_pulse, busy, zero_flag
  );

  // Counter side.
  modport slave (
    input  clear, load, load_val, count_enable, auto_reload,
    output count_out, expire_pulse, busy, zero_flag
  );
endinterface

// File: rtl/flex_down_counter.sv
// Loadable down-counter/timer with one-shot and periodic (auto-reload) modes.
// Latency: count and expire pulse update one clk edge after the qualifying input.
// Backpressure: none; clear > load > decrement are applied every cycle.
module flex_down_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input logic                clk,
  input logic                rst,
  flex_down_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  state_t                  state, state_nxt;
  logic [NUM_CNT_BITS-1:0] count, count_nxt;
  logic [NUM_CNT_BITS-1:0] reload_reg, reload_nxt;
  logic                    pulse, pulse_nxt;

  // State, count, reload value and the expiry pulse all live in one register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= CNT_ZERO;
      reload_reg <= CNT_ZERO;
      pulse      <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      pulse      <= pulse_nxt;
    end
  end

  // Next-state logic: clear beats load beats decrement; the pulse is only
  // raised when a RUN count of 1 is consumed without a competing load/clear.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_reg;
    pulse_nxt  = 1'b0;

    if (bus.clear) begin
      // reload_reg deliberately survives a clear.
      state_nxt = IDLE;
      count_nxt = CNT_ZERO;
    end else if (bus.load) begin
      count_nxt  = bus.load_val;
      reload_nxt = bus.load_val;
      // A zero load has nothing to count, so park in IDLE instead of RUN.
      state_nxt  = (bus.load_val != CNT_ZERO) ? RUN : IDLE;
    end else if (state == RUN && bus.count_enable) begin
      if (count > CNT_ONE) begin
        count_nxt = count - CNT_ONE;
      end else if (count == CNT_ONE) begin
        pulse_nxt = 1'b1;
        if (bus.auto_reload) begin
          // Jump straight from 1 to the reload value so 0 is never shown.
          count_nxt = reload_reg;
        end else begin
          count_nxt = CNT_ZERO;
          state_nxt = EXPIRED;
        end
      end
    end
  end

  assign bus.count_out    = count;
  assign bus.expire_pulse = pulse;
  assign bus.busy         = (state == RUN);
  assign bus.zero_flag    = (count == CNT_ZERO);

endmodule

// File: tb/tb_flex_down_counter.sv
// Directed bench for flex_down_counter: a vector table for the single-cycle
// behaviour plus hand-written sequences for asynchronous reset mid-count.
// Observed tuple is {count_out, expire_pulse, busy, zero_flag}.
module tb_flex_down_counter;

  logic clk;
  logic rst;

  flex_down_counter_if #(.NUM_CNT_BITS(4)) bus ();

  flex_down_counter #(.NUM_CNT_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       ar;
    logic [3:0] cnt;
    logic       pls;
    logic       bsy;
    logic       zro;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic void add(input logic clr, input logic ld, input logic [3:0] lv,
                              input logic en, input logic ar, input logic [3:0] cnt,
                              input logic pls, input logic bsy, input logic zro);
    vec_t v;
    v.clr = clr; v.ld = ld; v.lv = lv; v.en = en; v.ar = ar;
    v.cnt = cnt; v.pls = pls; v.bsy = bsy; v.zro = zro;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [3:0] cnt, input logic pls,
                     input logic bsy, input logic zro);
    logic [6:0] act;
    logic [6:0] exp;
    act = {bus.count_out, bus.expire_pulse, bus.busy, bus.zero_flag};
    exp = {cnt, pls, bsy, zro};
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got cnt=%0d pulse=%b busy=%b zero=%b, want cnt=%0d pulse=%b busy=%b zero=%b",
                  nm, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
  endtask

  task automatic drive(input logic clr, input logic ld, input logic [3:0] lv,
                       input logic en, input logic ar);
    bus.clear        = clr;
    bus.load         = ld;
    bus.load_val     = lv;
    bus.count_enable = en;
    bus.auto_reload  = ar;
  endtask

  initial begin
    // One-shot: load 3, enable held -> 3,2,1,0 with one pulse, then stuck in EXPIRED.
    add(0,1,4'd3,1,0, 4'd3,0,1,0);
    add(0,0,4'd0,1,0, 4'd2,0,1,0);
    add(0,0,4'd0,1,0, 4'd1,0,1,0);
    add(0,0,4'd0,1,0, 4'd0,1,0,1);
    add(0,0,4'd0,1,0, 4'd0,0,0,1);
    add(0,0,4'd0,1,1, 4'd0,0,0,1);
    // Periodic: load 4, 12 enabled cycles -> 3,2,1,4(pulse) repeated three times.
    add(0,1,4'd4,1,1, 4'd4,0,1,0);
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 3) add(0,0,4'd0,1,1, 4'd4,1,1,0);
      else            add(0,0,4'd0,1,1, 4'(3 - (i % 4)),0,1,0);
    end
    add(0,0,4'd0,0,1, 4'd4,0,1,0);
    add(0,0,4'd0,0,0, 4'd4,0,1,0);
    // Gapped enable: load 2, enables 1,0,0,1 -> 2,1,1,1,0 with one pulse at the end.
    add(0,1,4'd2,0,0, 4'd2,0,1,0);
    add(0,0,4'd0,1,0, 4'd1,0,1,0);
    add(0,0,4'd0,0,0, 4'd1,0,1,0);
    add(0,0,4'd0,0,0, 4'd1,0,1,0);
    add(0,0,4'd0,1,0, 4'd0,1,0,1);
    // Collisions: expiry with load wins for load; clear beats load; no pulse.
    add(0,1,4'd2,0,0, 4'd2,0,1,0);
    add(0,0,4'd0,1,0, 4'd1,0,1,0);
    add(0,1,4'd7,1,0, 4'd7,0,1,0);
    add(0,0,4'd0,1,0, 4'd6,0,1,0);
    add(0,1,4'd1,0,0, 4'd1,0,1,0);
    add(1,1,4'd5,1,1, 4'd0,0,0,1);
    add(0,0,4'd0,1,1, 4'd0,0,0,1);
    // Zero load with enable held: stays IDLE at 0, never pulses.
    add(0,1,4'd0,1,0, 4'd0,0,0,1);
    add(0,0,4'd0,1,0, 4'd0,0,0,1);
    add(0,0,4'd0,1,1, 4'd0,0,0,1);
    // Zero load aborts a running count.
    add(0,1,4'd5,0,0, 4'd5,0,1,0);
    add(0,1,4'd0,1,0, 4'd0,0,0,1);
    // Period of 1: pulse every enabled cycle, count stays at 1; then a one-shot
    // expiry when auto_reload drops in the expiry cycle.
    add(0,1,4'd1,0,1, 4'd1,0,1,0);
    add(0,0,4'd0,1,1, 4'd1,1,1,0);
    add(0,0,4'd0,1,1, 4'd1,1,1,0);
    add(0,0,4'd0,0,1, 4'd1,0,1,0);
    add(0,0,4'd0,1,0, 4'd0,1,0,1);
    // Max load value counts down normally.
    add(0,1,4'd15,1,0, 4'd15,0,1,0);
    add(0,0,4'd0,1,0,  4'd14,0,1,0);

    drive(0,0,4'd0,0,0);
    rst = 1'b1;
    #12;
    chk("reset_state", 4'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ar);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].pls, vecs[i].bsy, vecs[i].zro);
    end

    // Async reset mid-RUN with count 5: takes effect before the next edge.
    drive(0,1,4'd5,0,0);
    @(posedge clk); #1;
    chk("pre_rst_load5", 4'd5, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_rst_mid_run", 4'd0, 1'b0, 1'b0, 1'b1);
    #1;
    rst = 1'b0;

    // Async reset while the expiry pulse is high: the pulse is dropped at once.
    drive(0,1,4'd1,0,0);
    @(posedge clk); #1;
    chk("pre_rst_load1", 4'd1, 1'b0, 1'b1, 1'b0);
    drive(0,0,4'd0,1,0);
    @(posedge clk); #1;
    chk("pre_rst_pulse", 4'd0, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_kills_pulse", 4'd0, 1'b0, 1'b0, 1'b1);
    #1;
    rst = 1'b0;
    drive(0,0,4'd0,1,1);
    @(posedge clk); #1;
    chk("post_rst_idle", 4'd0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
